// File: rtl/spi_ram_master.sv
// spi_ram_master: SPI mode-0 master for SPI RAM devices.
// Issues READ (0x03) / WRITE (0x02), then a 24-bit address, then len+1 data bytes.
// On the client side it takes one command per start pulse and exchanges the data
// one byte at a time. All outputs are registered.
module spi_ram_master #(
  parameter int CLK_DIV  = 2,
  parameter int LEN_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                write,
  input  logic [23:0]         addr,
  input  logic [LEN_BITS-1:0] len,
  input  logic [7:0]          wr_data,
  output logic                wr_ready,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                done,
  output logic                spi_cs,
  output logic                spi_sck,
  output logic                spi_mosi,
  input  logic                spi_miso
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_HOLD = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  localparam logic [7:0]          CMD_WRITE = 8'h02;
  localparam logic [7:0]          CMD_READ  = 8'h03;
  localparam logic [7:0]          DIV_LAST  = 8'(CLK_DIV - 1);
  // The done cycle itself keeps CS high, so GAP only needs CLK_DIV-1 cycles of its own.
  localparam logic [7:0]          GAP_LAST  = (CLK_DIV > 1) ? 8'(CLK_DIV - 2) : 8'd0;
  localparam bit                  DIV_ONE   = (CLK_DIV == 1);
  localparam logic [LEN_BITS:0]   BYTE_ONE  = (LEN_BITS + 1)'(1);

  state_t              state;
  logic [7:0]          div_cnt;    // clk cycles spent in the current SCK half-period
  logic [2:0]          bit_idx;    // bit position within the current byte, 0 = MSB
  logic [1:0]          hdr_idx;    // which address byte is on the wire
  logic [LEN_BITS:0]   byte_cnt;   // data bytes finished so far; one bit wider than len
  logic                write_r;
  logic [23:0]         addr_r;
  logic [LEN_BITS-1:0] len_r;
  logic [6:0]          tx_sr;      // bits of the current byte not yet placed on MOSI
  logic [6:0]          rx_sr;      // bits of the current byte already sampled from MISO

  logic                tick_s;
  logic                last_data_s;
  logic [7:0]          next_byte_s;

  assign tick_s      = (div_cnt == DIV_LAST);
  assign last_data_s = (byte_cnt == {1'b0, len_r});

  // Select the byte that follows the one currently shifting out.
  always_comb begin
    next_byte_s = 8'h00;
    case (state)
      S_CMD: begin
        next_byte_s = addr_r[23:16];
      end
      S_ADDR: begin
        case (hdr_idx)
          2'd0:    next_byte_s = addr_r[15:8];
          2'd1:    next_byte_s = addr_r[7:0];
          default: next_byte_s = write_r ? wr_data : 8'h00;
        endcase
      end
      S_DATA: begin
        next_byte_s = write_r ? wr_data : 8'h00;
      end
      default: begin
        next_byte_s = 8'h00;
      end
    endcase
  end

  // Transaction sequencer: SCK generation, shifting, client handshakes and CS framing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      div_cnt  <= 8'd0;
      bit_idx  <= 3'd0;
      hdr_idx  <= 2'd0;
      byte_cnt <= '0;
      write_r  <= 1'b0;
      addr_r   <= 24'h000000;
      len_r    <= '0;
      tx_sr    <= 7'h00;
      rx_sr    <= 7'h00;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      wr_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_cs   <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      done     <= 1'b0;
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            write_r  <= write;
            addr_r   <= addr;
            len_r    <= len;
            tx_sr    <= write ? CMD_WRITE[6:0] : CMD_READ[6:0];
            spi_mosi <= write ? CMD_WRITE[7] : CMD_READ[7];
            spi_cs   <= 1'b0;
            spi_sck  <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= 8'd0;
            bit_idx  <= 3'd0;
            hdr_idx  <= 2'd0;
            byte_cnt <= '0;
            state    <= S_CMD;
          end else begin
            spi_cs   <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
          end
        end

        S_CMD, S_ADDR, S_DATA: begin
          if (!tick_s) begin
            div_cnt <= div_cnt + 8'd1;
          end else if (!spi_sck) begin
            // Rising edge: MISO is sampled in this same cycle.
            div_cnt <= 8'd0;
            spi_sck <= 1'b1;
            if ((state == S_DATA) && !write_r) begin
              rx_sr <= {rx_sr[5:0], spi_miso};
              if (bit_idx == 3'd7) begin
                rd_data  <= {rx_sr, spi_miso};
                rd_valid <= 1'b1;
              end else begin
                rd_valid <= 1'b0;
              end
            end else begin
              rx_sr <= rx_sr;
            end
          end else begin
            // Falling edge: the only point (besides the first bit) where MOSI moves.
            div_cnt <= 8'd0;
            spi_sck <= 1'b0;
            if (bit_idx != 3'd7) begin
              bit_idx  <= bit_idx + 3'd1;
              spi_mosi <= tx_sr[6];
              tx_sr    <= {tx_sr[5:0], 1'b0};
            end else if ((state == S_DATA) && last_data_s) begin
              bit_idx  <= 3'd0;
              spi_mosi <= 1'b0;
              state    <= S_HOLD;
            end else begin
              bit_idx  <= 3'd0;
              spi_mosi <= next_byte_s[7];
              tx_sr    <= next_byte_s[6:0];
              case (state)
                S_CMD: begin
                  state <= S_ADDR;
                end
                S_ADDR: begin
                  if (hdr_idx == 2'd2) begin
                    wr_ready <= write_r;
                    state    <= S_DATA;
                  end else begin
                    hdr_idx <= hdr_idx + 2'd1;
                  end
                end
                S_DATA: begin
                  wr_ready <= write_r;
                  byte_cnt <= byte_cnt + BYTE_ONE;
                end
                default: begin
                  state <= S_IDLE;
                end
              endcase
            end
          end
        end

        S_HOLD: begin
          if (!tick_s) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= 8'd0;
            spi_cs  <= 1'b1;
            if (DIV_ONE) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        default: begin
          busy     <= 1'b0;
          spi_cs   <= 1'b1;
          spi_sck  <= 1'b0;
          spi_mosi <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
